// File: rtl/button_conditioner.sv
// Multi-channel push-button front end: synchroniser, counter debouncer,
// press/release edge pulses and optional per-channel auto-repeat.
module button_conditioner #(
    parameter int N_BUTTONS       = 2,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int REPEAT_DELAY    = 12500000,
    parameter int REPEAT_RATE     = 2500000
) (
    input  logic                 clock_25,
    input  logic                 reset,
    input  logic [N_BUTTONS-1:0] button_P,
    input  logic [N_BUTTONS-1:0] repeat_en,
    output logic [N_BUTTONS-1:0] button_sync,
    output logic [N_BUTTONS-1:0] button_stable,
    output logic [N_BUTTONS-1:0] press_pulse,
    output logic [N_BUTTONS-1:0] release_pulse,
    output logic                 any_press
);

    // state      | meaning
    // RPT_IDLE   | not repeating (released, repeat disabled, or enabled mid-hold)
    // RPT_DELAY  | held since an accepted press, waiting for the first repeat
    // RPT_REPEAT | repeating every REPEAT_RATE clocks
    typedef enum logic [1:0] {
        RPT_IDLE,
        RPT_DELAY,
        RPT_REPEAT
    } rpt_state_e;

    localparam int DCW  = $clog2(DEBOUNCE_CYCLES);
    localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int RCW  = (RMAX > 1) ? $clog2(RMAX) : 1;

    localparam logic [DCW-1:0] DB_LAST = DCW'(DEBOUNCE_CYCLES - 1);
    localparam logic [RCW-1:0] RD_LAST = RCW'(REPEAT_DELAY - 1);
    localparam logic [RCW-1:0] RR_LAST = RCW'(REPEAT_RATE - 1);

    logic [N_BUTTONS-1:0] press_d;
    logic                 any_press_q;

    for (genvar i = 0; i < N_BUTTONS; i++) begin : g_ch
        logic [SYNC_STAGES-1:0] sync_q;
        logic [DCW-1:0]         cnt_q, cnt_d;
        logic                   stable_q, stable_d;
        logic                   press_q, release_q, release_d;
        logic                   accept;
        logic                   rpt_fire;
        rpt_state_e             state_q, state_d;
        logic [RCW-1:0]         rcnt_q, rcnt_d;

        always_ff @(posedge clock_25 or negedge reset) begin
            if (!reset) begin
                sync_q    <= '0;
                cnt_q     <= '0;
                stable_q  <= 1'b0;
                press_q   <= 1'b0;
                release_q <= 1'b0;
                state_q   <= RPT_IDLE;
                rcnt_q    <= '0;
            end else begin
                sync_q    <= {sync_q[SYNC_STAGES-2:0], button_P[i]};
                cnt_q     <= cnt_d;
                stable_q  <= stable_d;
                press_q   <= press_d[i];
                release_q <= release_d;
                state_q   <= state_d;
                rcnt_q    <= rcnt_d;
            end
        end

        always_comb begin
            cnt_d    = cnt_q;
            stable_d = stable_q;
            accept   = 1'b0;
            if (sync_q[SYNC_STAGES-1] == stable_q) begin
                cnt_d = '0;
            end else if (cnt_q == DB_LAST) begin
                stable_d = sync_q[SYNC_STAGES-1];
                cnt_d    = '0;
                accept   = 1'b1;
            end else begin
                cnt_d = cnt_q + DCW'(1);
            end
        end

        // An accepted edge takes priority so a release can never coincide
        // with a repeat pulse, and a press only arms repeating if enabled now.
        always_comb begin
            state_d  = state_q;
            rcnt_d   = rcnt_q;
            rpt_fire = 1'b0;
            if (accept) begin
                rcnt_d  = '0;
                state_d = (stable_d && repeat_en[i]) ? RPT_DELAY : RPT_IDLE;
            end else if (!stable_q || !repeat_en[i]) begin
                rcnt_d  = '0;
                state_d = RPT_IDLE;
            end else begin
                case (state_q)
                    RPT_DELAY: begin
                        if (rcnt_q == RD_LAST) begin
                            rpt_fire = 1'b1;
                            rcnt_d   = '0;
                            state_d  = RPT_REPEAT;
                        end else begin
                            rcnt_d = rcnt_q + RCW'(1);
                        end
                    end
                    RPT_REPEAT: begin
                        if (rcnt_q == RR_LAST) begin
                            rpt_fire = 1'b1;
                            rcnt_d   = '0;
                        end else begin
                            rcnt_d = rcnt_q + RCW'(1);
                        end
                    end
                    default: begin
                        rcnt_d  = '0;
                        state_d = RPT_IDLE;
                    end
                endcase
            end
        end

        assign release_d        = accept && !stable_d;
        assign press_d[i]       = (accept && stable_d) || rpt_fire;
        assign button_sync[i]   = sync_q[SYNC_STAGES-1];
        assign button_stable[i] = stable_q;
        assign press_pulse[i]   = press_q;
        assign release_pulse[i] = release_q;
    end

    always_ff @(posedge clock_25 or negedge reset) begin
        if (!reset) begin
            any_press_q <= 1'b0;
        end else begin
            any_press_q <= |press_d;
        end
    end

    assign any_press = any_press_q;

endmodule

// File: tb/tb_button_conditioner.sv
// Scoreboard bench for button_conditioner: a window/elapsed-time reference
// model queues expected pulses, a monitor pops and compares them.
module tb_button_conditioner;
    localparam int NB = 2;
    localparam int SS = 2;
    localparam int DB = 4;
    localparam int RD = 10;
    localparam int RR = 3;
    localparam int HMAX = 2048;

    logic          clock_25 = 1'b0;
    logic          reset    = 1'b0;
    logic [NB-1:0] button_P = '0;
    logic [NB-1:0] repeat_en = '0;
    logic [NB-1:0] button_sync, button_stable, press_pulse, release_pulse;
    logic          any_press;

    button_conditioner #(
        .N_BUTTONS(NB), .SYNC_STAGES(SS), .DEBOUNCE_CYCLES(DB),
        .REPEAT_DELAY(RD), .REPEAT_RATE(RR)
    ) dut (
        .clock_25(clock_25), .reset(reset), .button_P(button_P),
        .repeat_en(repeat_en), .button_sync(button_sync),
        .button_stable(button_stable), .press_pulse(press_pulse),
        .release_pulse(release_pulse), .any_press(any_press)
    );

    always #5 clock_25 = ~clock_25;

    typedef struct {
        int            cyc;
        logic [NB-1:0] pr;
        logic [NB-1:0] rl;
    } ev_t;

    ev_t  sbq[$];
    int   checks = 0;
    int   failures = 0;
    int   g_edge = 0;
    int   m_n = 0;
    logic in_reset = 1'b1;
    logic [NB-1:0] exp_stable = '0;
    logic [NB-1:0] exp_sync = '0;
    logic hist_in [NB][HMAX];
    logic m_stable [NB];
    logic m_armed [NB];
    int   m_press [NB];
    int   obs_p0[$], obs_p1[$], obs_r1[$];

    function automatic logic inval(int c, int k);
        return (k < 0) ? 1'b0 : hist_in[c][k];
    endfunction

    task automatic model_clear();
        m_n = 0;
        for (int c = 0; c < NB; c++) begin
            m_stable[c] = 1'b0;
            m_armed[c]  = 1'b0;
            m_press[c]  = 0;
        end
    endtask

    task automatic check_int(input string name, input int act, input int expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, expv);
        end
    endtask

    // Drive one clock of stimulus and predict the outputs after the next edge.
    // A level is accepted once the last DB synchronised samples all differ
    // from the current stable level; repeats fire at elapsed times RD, RD+RR, ...
    task automatic drive(input logic [NB-1:0] bp, input logic [NB-1:0] en);
        ev_t  e;
        logic acc;
        int   d;
        button_P  = bp;
        repeat_en = en;
        e.cyc = g_edge;
        e.pr  = '0;
        e.rl  = '0;
        for (int c = 0; c < NB; c++) begin
            hist_in[c][m_n] = bp[c];
            exp_sync[c] = inval(c, m_n - 1);
            acc = 1'b1;
            for (int k = m_n - SS - DB + 1; k <= m_n - SS; k++)
                if (inval(c, k) == m_stable[c]) acc = 1'b0;
            if (acc) begin
                m_stable[c] = !m_stable[c];
                if (m_stable[c]) begin
                    e.pr[c]    = 1'b1;
                    m_armed[c] = en[c];
                    m_press[c] = m_n;
                end else begin
                    e.rl[c]    = 1'b1;
                    m_armed[c] = 1'b0;
                end
            end else if (m_armed[c]) begin
                if (!en[c]) begin
                    m_armed[c] = 1'b0;
                end else begin
                    d = m_n - m_press[c];
                    if (d == RD || (d > RD && (d - RD) % RR == 0)) e.pr[c] = 1'b1;
                end
            end
            exp_stable[c] = m_stable[c];
        end
        if (e.pr != '0 || e.rl != '0) sbq.push_back(e);
        @(negedge clock_25);
        m_n++;
        g_edge++;
    endtask

    task automatic do_reset(input int ncyc);
        reset    = 1'b0;
        in_reset = 1'b1;
        repeat (ncyc) @(negedge clock_25);
        reset    = 1'b1;
        in_reset = 1'b0;
        model_clear();
    endtask

    initial begin : monitor
        ev_t e;
        forever begin
            @(posedge clock_25);
            #1;
            if (in_reset) begin
                checks++;
                if ({button_sync, button_stable, press_pulse, release_pulse, any_press} !== '0) begin
                    failures++;
                    $display("FAIL reset_zero: sync=%b stable=%b press=%b release=%b any=%b required all 0",
                             button_sync, button_stable, press_pulse, release_pulse, any_press);
                end
            end else begin
                checks++;
                if (button_stable !== exp_stable) begin
                    failures++;
                    $display("FAIL stable@%0d: got %b expected %b", g_edge, button_stable, exp_stable);
                end
                checks++;
                if (button_sync !== exp_sync) begin
                    failures++;
                    $display("FAIL sync@%0d: got %b expected %b", g_edge, button_sync, exp_sync);
                end
                if (press_pulse[0])   obs_p0.push_back(g_edge);
                if (press_pulse[1])   obs_p1.push_back(g_edge);
                if (release_pulse[1]) obs_r1.push_back(g_edge);
                if (sbq.size() > 0 && sbq[0].cyc == g_edge) begin
                    e = sbq.pop_front();
                    checks++;
                    if (press_pulse !== e.pr || release_pulse !== e.rl || any_press !== (|e.pr)) begin
                        failures++;
                        $display("FAIL pulse@%0d: press=%b release=%b any=%b expected press=%b release=%b any=%b",
                                 g_edge, press_pulse, release_pulse, any_press, e.pr, e.rl, |e.pr);
                    end
                end else if ((press_pulse | release_pulse) != '0 || any_press) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected@%0d: press=%b release=%b any=%b expected none",
                             g_edge, press_pulse, release_pulse, any_press);
                end
            end
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        int base;
        int exp_rep[8] = '{0, 10, 13, 16, 19, 22, 25, 28};
        logic [NB-1:0] bp, en;

        // reset with both buttons held
        button_P = 2'b11;
        repeat (3) @(negedge clock_25);
        reset    = 1'b1;
        in_reset = 1'b0;
        model_clear();
        base = g_edge;
        repeat (12) drive(2'b11, 2'b00);
        check_int("rst_p0_edge", (obs_p0.size() > 0) ? obs_p0[0] - base : -1, 5);
        check_int("rst_p1_edge", (obs_p1.size() > 0) ? obs_p1[0] - base : -1, 5);
        check_int("rst_p0_count", obs_p0.size(), 1);
        repeat (10) drive(2'b00, 2'b00);

        // glitch of 3 clocks rejected, 4 clocks accepted
        obs_p0.delete();
        repeat (3) drive(2'b01, 2'b00);
        repeat (8) drive(2'b00, 2'b00);
        check_int("glitch3_press", obs_p0.size(), 0);
        base = g_edge;
        repeat (4) drive(2'b01, 2'b00);
        repeat (10) drive(2'b00, 2'b00);
        check_int("glitch4_edge", (obs_p0.size() > 0) ? obs_p0[0] - base : -1, 5);

        // long hold then release, no repeat
        obs_p1.delete();
        obs_r1.delete();
        repeat (20) drive(2'b10, 2'b00);
        base = g_edge;
        repeat (10) drive(2'b00, 2'b00);
        check_int("hold_press_count", obs_p1.size(), 1);
        check_int("release_count", obs_r1.size(), 1);
        check_int("release_edge", (obs_r1.size() > 0) ? obs_r1[0] - base : -1, 5);

        // auto-repeat, then disable mid-hold and re-enable while still held
        obs_p0.delete();
        base = g_edge + 5;
        repeat (35) drive(2'b01, 2'b01);
        check_int("repeat_count", obs_p0.size(), 8);
        for (int k = 0; k < 8; k++)
            check_int($sformatf("repeat_rel%0d", k),
                      (obs_p0.size() > k) ? obs_p0[k] - base : -1, exp_rep[k]);
        repeat (10) drive(2'b01, 2'b00);
        repeat (15) drive(2'b01, 2'b01);
        check_int("repeat_stopped", obs_p0.size(), 8);
        repeat (10) drive(2'b00, 2'b00);

        // simultaneous press
        obs_p0.delete();
        obs_p1.delete();
        base = g_edge;
        repeat (8) drive(2'b11, 2'b00);
        repeat (10) drive(2'b00, 2'b00);
        check_int("simul_p0_edge", (obs_p0.size() > 0) ? obs_p0[0] - base : -1, 5);
        check_int("simul_p1_edge", (obs_p1.size() > 0) ? obs_p1[0] - base : -1, 5);

        // reset during the repeat delay, button still held across it
        repeat (9) drive(2'b01, 2'b01);
        do_reset(3);
        check_int("midrst_queue_empty", sbq.size(), 0);
        obs_p0.delete();
        base = g_edge;
        repeat (18) drive(2'b01, 2'b01);
        check_int("midrst_press_count", obs_p0.size(), 2);
        check_int("midrst_press_edge", (obs_p0.size() > 0) ? obs_p0[0] - base : -1, 5);
        check_int("midrst_repeat_edge", (obs_p0.size() > 1) ? obs_p0[1] - base : -1, 15);
        repeat (10) drive(2'b00, 2'b00);

        // randomized: bouncy then slow-changing levels, occasional enable flips
        bp = '0;
        en = '0;
        for (int t = 0; t < 500; t++) begin
            for (int c = 0; c < NB; c++) begin
                if ($urandom_range(t < 250 ? 3 : 24, 0) == 0) bp[c] = !bp[c];
                if ($urandom_range(19, 0) == 0) en[c] = !en[c];
            end
            drive(bp, en);
        end
        repeat (10) drive(2'b00, 2'b00);
        check_int("queue_drained", sbq.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
